// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce scheduler.
package debounce_pkg;

  typedef enum logic {
    IDLE,
    TIMING
  } state_t;

  localparam int DEFAULT_TICKS    = 1000000;
  localparam int DEFAULT_CHANNELS = 4;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer sharing one timer, granted round-robin.
// Define DEBOUNCE_SCHEDULER_SYNC_EN to add a 2-flop synchronizer per input.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int TICKS    = DEFAULT_TICKS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         i_switch,
  output logic [CHANNELS-1:0]         o_switch,
  output logic [CHANNELS-1:0]         o_press,
  output logic [CHANNELS-1:0]         o_release,
  output logic                        o_busy,
  output logic [$clog2(CHANNELS)-1:0] o_active_ch
);

  localparam int CW    = $clog2(CHANNELS);
  localparam int CNT_W = $clog2(TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS - 1);
  localparam logic [CW-1:0]    LAST_CH = CW'(CHANNELS - 1);

  logic [CHANNELS-1:0] sw_s;

`ifdef DEBOUNCE_SCHEDULER_SYNC_EN
  for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
    sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (i_switch[g]),
      .q   (sw_s[g])
    );
  end
`else
  assign sw_s = i_switch;
`endif

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CHANNELS-1:0] sw_q, sw_n;
  logic [CHANNELS-1:0] press_q, press_n;
  logic [CHANNELS-1:0] rel_q, rel_n;
  logic [CW-1:0]       owner, owner_n;
  logic [CW-1:0]       last, last_n;
  logic [CHANNELS-1:0] pend;

  // First pending channel after last_v, wrapping around.
  function automatic logic [CW-1:0] rr_pick(input logic [CHANNELS-1:0] pend_v,
                                            input logic [CW-1:0]       last_v);
    logic [CW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last_v;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(last_v) + k) % CHANNELS;
      if (!found && pend_v[CW'(idx)]) begin
        pick  = CW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign pend = sw_s ^ sw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sw_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
      owner   <= '0;
      last    <= LAST_CH;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sw_q    <= sw_n;
      press_q <= press_n;
      rel_q   <= rel_n;
      owner   <= owner_n;
      last    <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sw_n    = sw_q;
    press_n = '0;
    rel_n   = '0;
    owner_n = owner;
    last_n  = last;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (|pend) begin
          owner_n = rr_pick(pend, last);
          state_n = TIMING;
        end
      end
      TIMING: begin
        // Abort and commit both advance last so a bouncing channel yields.
        if (sw_s[owner] == sw_q[owner]) begin
          state_n = IDLE;
          cnt_n   = '0;
          last_n  = owner;
        end else if (cnt == CNT_MAX) begin
          sw_n[owner] = ~sw_q[owner];
          if (sw_q[owner]) rel_n[owner] = 1'b1;
          else             press_n[owner] = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
          last_n  = owner;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_switch    = sw_q;
  assign o_press     = press_q;
  assign o_release   = rel_q;
  assign o_busy      = (state == TIMING);
  assign o_active_ch = owner;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with CHANNELS=4, TICKS=4, direct sampling.
module tb_debounce_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] i_switch;
  logic [3:0] o_switch;
  logic [3:0] o_press;
  logic [3:0] o_release;
  logic       o_busy;
  logic [1:0] o_active_ch;

  int checks   = 0;
  int failures = 0;

  debounce_scheduler #(
    .CHANNELS (4),
    .TICKS    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_switch    (i_switch),
    .o_switch    (o_switch),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_busy      (o_busy),
    .o_active_ch (o_active_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic [3:0] sw;
    logic [3:0] press;
    logic [3:0] rel;
    logic       busy;
    logic [1:0] ch;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(input logic [3:0] in, input logic [3:0] sw,
                              input logic [3:0] press, input logic [3:0] rel,
                              input logic busy, input logic [1:0] ch);
    vec_t v;
    v.in = in; v.sw = sw; v.press = press; v.rel = rel; v.busy = busy; v.ch = ch;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {o_switch, o_press, o_release, o_busy, o_active_ch};
  endfunction

  function automatic logic [14:0] pack(input vec_t v);
    return {v.sw, v.press, v.rel, v.busy, v.ch};
  endfunction

  int grants;
  int ch1_grant_no;
  int overlap;
  int ch1_press;
  logic prev_busy;

  initial begin
    // channel 2 bounces, channel 0 presses, 1 and 3 together, channel 0 releases
    vt[0]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    vt[1]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2);
    vt[2]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2);
    vt[3]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2);
    vt[4]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2);
    vt[5]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0);
    vt[6]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0);
    vt[7]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0);
    vt[8]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0);
    vt[9]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0);
    vt[10] = mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
    vt[11] = mk(4'b1011, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd1);
    vt[12] = mk(4'b1011, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd1);
    vt[13] = mk(4'b1011, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd1);
    vt[14] = mk(4'b1011, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd1);
    vt[15] = mk(4'b1011, 4'b0011, 4'b0010, 4'b0000, 1'b0, 2'd1);
    vt[16] = mk(4'b1011, 4'b0011, 4'b0000, 4'b0000, 1'b1, 2'd3);
    vt[17] = mk(4'b1011, 4'b0011, 4'b0000, 4'b0000, 1'b1, 2'd3);
    vt[18] = mk(4'b1011, 4'b0011, 4'b0000, 4'b0000, 1'b1, 2'd3);
    vt[19] = mk(4'b1011, 4'b0011, 4'b0000, 4'b0000, 1'b1, 2'd3);
    vt[20] = mk(4'b1011, 4'b1011, 4'b1000, 4'b0000, 1'b0, 2'd3);
    vt[21] = mk(4'b1011, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd3);
    vt[22] = mk(4'b1010, 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd0);
    vt[23] = mk(4'b1010, 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd0);
    vt[24] = mk(4'b1010, 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd0);
    vt[25] = mk(4'b1010, 4'b1011, 4'b0000, 4'b0000, 1'b1, 2'd0);
    vt[26] = mk(4'b1010, 4'b1010, 4'b0000, 4'b0001, 1'b0, 2'd0);
    vt[27] = mk(4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0, 2'd0);

    rst      = 1'b1;
    i_switch = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", 32'(outs()), 32'(15'd0));

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      i_switch = vt[i].in;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(pack(vt[i])));
    end

    // Reset while channel 0 is being timed at count 2
    @(negedge clk);
    i_switch = 4'b1011;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'({o_busy, o_active_ch}), 32'({1'b1, 2'd0}));
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", 32'(outs()), 32'(15'd0));
    @(posedge clk);
    #1;
    check("rst_held", 32'(outs()), 32'(15'd0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_grant", 32'(outs()), 32'({4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0}));

    // Channel 0 chatters while channel 1 waits steady high
    @(negedge clk);
    rst      = 1'b1;
    i_switch = 4'b0000;
    @(negedge clk);
    rst          = 1'b0;
    grants       = 0;
    ch1_grant_no = 0;
    overlap      = 0;
    ch1_press    = 0;
    prev_busy    = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      i_switch = {2'b00, 1'b1, (c % 2 == 0)};
      @(posedge clk);
      #1;
      if (o_busy && !prev_busy) begin
        grants++;
        if (o_active_ch == 2'd1 && ch1_grant_no == 0) ch1_grant_no = grants;
      end
      prev_busy = o_busy;
      if ($countones(o_press | o_release) > 1) overlap++;
      if (o_press[1]) ch1_press++;
    end
    check("starve_ch1_grant_no", 32'(ch1_grant_no), 32'd2);
    check("starve_ch1_committed", 32'(o_switch[1]), 32'd1);
    check("starve_ch0_never", 32'(o_switch[0]), 32'd0);
    check("starve_ch1_press_once", 32'(ch1_press), 32'd1);
    check("pulse_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
